// File: rtl/exmem_pkg.sv
// Shared types for the EX->MEM pipeline chain.
// Holds the per-entry control bundle, a reference slice layout at default
// widths, and the maximum supported chain depth.
package exmem_pkg;

  localparam int MAX_STAGES = 4;

  // Control bits carried with every entry. trap_hit and sc_ok are resolved
  // once at slice0 capture and then only travel down the chain.
  typedef struct packed {
    logic Trap;
    logic TrapCond;
    logic LLSC;
    logic MemRead;
    logic MemWrite;
    logic MemHalf;
    logic MemByte;
    logic MemSignExtend;
    logic RegWrite;
    logic MemtoReg;
    logic trap_hit;
    logic sc_ok;
  } exmem_ctrl_t;

  // Slice layout at the default 32-bit data / 5-bit register widths.
  typedef struct packed {
    logic        valid;
    exmem_ctrl_t ctrl;
    logic [31:0] result;
    logic [31:0] wdata;
    logic [4:0]  regdst;
  } exmem_slice_t;

endpackage

// File: rtl/exmem_slice.sv
// One register slice of the EX->MEM chain.
// Flush clears valid even while stalled; Stall holds everything.
// Only the valid bit is reset; payload is qualified by valid downstream.
module exmem_slice
  import exmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              valid_i,
  input  exmem_ctrl_t       ctrl_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_W-1:0]  regdst_i,
  output logic              valid_o,
  output exmem_ctrl_t       ctrl_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [REG_W-1:0]  regdst_o
);

  logic              valid_q, valid_d;
  exmem_ctrl_t       ctrl_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] wdata_q;
  logic [REG_W-1:0]  regdst_q;

  // Next valid: flush beats stall, stall holds, otherwise advance.
  always_comb begin
    valid_d = valid_q;
    if (Flush)       valid_d = 1'b0;
    else if (!Stall) valid_d = valid_i;
  end

  // Valid register, the only state that is reset.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // Payload register; contents under a cleared valid are don't-care.
  always_ff @(posedge clk) begin
    if (!Stall) begin
      ctrl_q   <= ctrl_i;
      result_q <= result_i;
      wdata_q  <= wdata_i;
      regdst_q <= regdst_i;
    end
  end

  assign valid_o  = valid_q;
  assign ctrl_o   = ctrl_q;
  assign result_o = result_q;
  assign wdata_o  = wdata_q;
  assign regdst_o = regdst_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register chain, STAGES slices deep (clamped to 1..4).
// Resolves traps and LL/SC status at capture, tracks the link bit, and
// qualifies every MEM-side output with the final slice valid.
// Optional build macro EXMEM_FWD_EN adds a forwarding scan over all slices.
module ex_mem_pipe
  import exmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              in_valid,
  input  logic              Trap,
  input  logic              TrapCond,
  input  logic              LLSC,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemHalf,
  input  logic              MemByte,
  input  logic              MemSignExtend,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [REG_W-1:0]  RegDstOut,
  output logic              out_valid,
  output logic              m_MemRead,
  output logic              m_MemWrite,
  output logic              m_MemHalf,
  output logic              m_MemByte,
  output logic              m_MemSignExtend,
  output logic              m_RegWrite,
  output logic              m_MemtoReg,
  output logic [DATA_W-1:0] m_ALUResult,
  output logic [DATA_W-1:0] m_WriteData,
  output logic [REG_W-1:0]  m_RegDst,
  output logic              ExcTr,
  output logic              LLBit
`ifdef EXMEM_FWD_EN
  ,
  input  logic [REG_W-1:0]  fwd_rs,
  input  logic [REG_W-1:0]  fwd_rt,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic [DATA_W-1:0] fwd_rt_data
`endif
);

  localparam int DEPTH = (STAGES > MAX_STAGES) ? MAX_STAGES :
                         ((STAGES < 1) ? 1 : STAGES);
  localparam int LAST  = DEPTH - 1;

  logic [DEPTH-1:0]             vld;
  exmem_ctrl_t [DEPTH-1:0]      ctl;
  logic [DEPTH-1:0][DATA_W-1:0] res;
  logic [DEPTH-1:0][DATA_W-1:0] wdt;
  logic [DEPTH-1:0][REG_W-1:0]  rdst;

  logic              is_ll, is_sc;
  exmem_ctrl_t       cap_ctrl;
  logic [DATA_W-1:0] cap_result;
  logic              llbit_q, llbit_d;

  // Capture-side resolution of trap and LL/SC status for slice0.
  always_comb begin
    is_ll = in_valid & LLSC & MemRead;
    is_sc = in_valid & LLSC & MemWrite;
    cap_ctrl.Trap          = Trap;
    cap_ctrl.TrapCond      = TrapCond;
    cap_ctrl.LLSC          = LLSC;
    cap_ctrl.MemRead       = MemRead;
    cap_ctrl.MemWrite      = MemWrite & ~(is_sc & ~llbit_q);
    cap_ctrl.MemHalf       = MemHalf;
    cap_ctrl.MemByte       = MemByte;
    cap_ctrl.MemSignExtend = MemSignExtend;
    cap_ctrl.RegWrite      = RegWrite;
    cap_ctrl.MemtoReg      = MemtoReg;
    cap_ctrl.trap_hit      = in_valid & Trap & (ALUResult[0] == TrapCond);
    cap_ctrl.sc_ok         = is_sc & llbit_q;
    cap_result = ALUResult;
    if (is_sc) cap_result = {{(DATA_W-1){1'b0}}, llbit_q};
  end

  // Link-bit next state: flush clears, stall holds, SC clears, LL sets.
  always_comb begin
    llbit_d = llbit_q;
    if (Flush)       llbit_d = 1'b0;
    else if (!Stall) begin
      if (is_sc)      llbit_d = 1'b0;
      else if (is_ll) llbit_d = 1'b1;
    end
  end

  // Link-bit register.
  always_ff @(posedge clk) begin
    if (rst) llbit_q <= 1'b0;
    else     llbit_q <= llbit_d;
  end

  assign LLBit = llbit_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slice
    if (g == 0) begin : g_head
      exmem_slice #(.DATA_W(DATA_W), .REG_W(REG_W)) u_slice (
        .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
        .valid_i(in_valid), .ctrl_i(cap_ctrl), .result_i(cap_result),
        .wdata_i(ReadData2), .regdst_i(RegDstOut),
        .valid_o(vld[g]), .ctrl_o(ctl[g]), .result_o(res[g]),
        .wdata_o(wdt[g]), .regdst_o(rdst[g])
      );
    end else begin : g_body
      exmem_slice #(.DATA_W(DATA_W), .REG_W(REG_W)) u_slice (
        .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
        .valid_i(vld[g-1]), .ctrl_i(ctl[g-1]), .result_i(res[g-1]),
        .wdata_i(wdt[g-1]), .regdst_i(rdst[g-1]),
        .valid_o(vld[g]), .ctrl_o(ctl[g]), .result_o(res[g]),
        .wdata_o(wdt[g]), .regdst_o(rdst[g])
      );
    end
  end

  // Final-slice qualification; a trapped entry never writes or accesses memory.
  always_comb begin
    out_valid       = vld[LAST];
    ExcTr           = vld[LAST] & ctl[LAST].trap_hit;
    m_MemRead       = vld[LAST] & ctl[LAST].MemRead  & ~ctl[LAST].trap_hit;
    m_MemWrite      = vld[LAST] & ctl[LAST].MemWrite & ~ctl[LAST].trap_hit;
    m_RegWrite      = vld[LAST] & ctl[LAST].RegWrite & ~ctl[LAST].trap_hit;
    m_MemHalf       = vld[LAST] & ctl[LAST].MemHalf;
    m_MemByte       = vld[LAST] & ctl[LAST].MemByte;
    m_MemSignExtend = vld[LAST] & ctl[LAST].MemSignExtend;
    m_MemtoReg      = vld[LAST] & ctl[LAST].MemtoReg;
    m_ALUResult     = vld[LAST] ? res[LAST]  : '0;
    m_WriteData     = vld[LAST] ? wdt[LAST]  : '0;
    m_RegDst        = vld[LAST] ? rdst[LAST] : '0;
  end

  // Bits that are only meaningful at capture time.
  logic unused_ctrl;
  assign unused_ctrl = ^{ctl[LAST].Trap, ctl[LAST].TrapCond,
                         ctl[LAST].LLSC, ctl[LAST].sc_ok};

`ifdef EXMEM_FWD_EN
  // Forwarding scan, oldest first so the youngest matching slice wins.
  always_comb begin
    fwd_rs_hit  = 1'b0;
    fwd_rt_hit  = 1'b0;
    fwd_rs_data = '0;
    fwd_rt_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (vld[k] && ctl[k].RegWrite && !ctl[k].trap_hit &&
          (fwd_rs != '0) && (rdst[k] == fwd_rs)) begin
        fwd_rs_hit  = 1'b1;
        fwd_rs_data = ctl[k].MemtoReg ? '0 : res[k];
      end
      if (vld[k] && ctl[k].RegWrite && !ctl[k].trap_hit &&
          (fwd_rt != '0) && (rdst[k] == fwd_rt)) begin
        fwd_rt_hit  = 1'b1;
        fwd_rt_data = ctl[k].MemtoReg ? '0 : res[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe at STAGES=3.
// Control vectors are ordered {Trap,TrapCond,LLSC,MemRead,MemWrite,MemHalf,
// MemByte,MemSignExtend,RegWrite,MemtoReg}; observed controls are ordered
// {out_valid,ExcTr,MemRead,MemWrite,MemHalf,MemByte,MemSignExtend,RegWrite,MemtoReg}.
module tb_ex_mem_pipe;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int ST = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, Stall, Flush, in_valid;
  logic Trap, TrapCond, LLSC, MemRead, MemWrite, MemHalf, MemByte;
  logic MemSignExtend, RegWrite, MemtoReg;
  logic [DW-1:0] ALUResult, ReadData2;
  logic [RW-1:0] RegDstOut;
  logic out_valid, m_MemRead, m_MemWrite, m_MemHalf, m_MemByte;
  logic m_MemSignExtend, m_RegWrite, m_MemtoReg, ExcTr, LLBit;
  logic [DW-1:0] m_ALUResult, m_WriteData;
  logic [RW-1:0] m_RegDst;
`ifdef EXMEM_FWD_EN
  logic [RW-1:0] fwd_rs, fwd_rt;
  logic fwd_rs_hit, fwd_rt_hit;
  logic [DW-1:0] fwd_rs_data, fwd_rt_data;
`endif

  ex_mem_pipe #(.DATA_W(DW), .REG_W(RW), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .in_valid(in_valid),
    .Trap(Trap), .TrapCond(TrapCond), .LLSC(LLSC), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemHalf(MemHalf), .MemByte(MemByte),
    .MemSignExtend(MemSignExtend), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUResult(ALUResult), .ReadData2(ReadData2), .RegDstOut(RegDstOut),
    .out_valid(out_valid), .m_MemRead(m_MemRead), .m_MemWrite(m_MemWrite),
    .m_MemHalf(m_MemHalf), .m_MemByte(m_MemByte),
    .m_MemSignExtend(m_MemSignExtend), .m_RegWrite(m_RegWrite),
    .m_MemtoReg(m_MemtoReg), .m_ALUResult(m_ALUResult),
    .m_WriteData(m_WriteData), .m_RegDst(m_RegDst), .ExcTr(ExcTr),
    .LLBit(LLBit)
`ifdef EXMEM_FWD_EN
    , .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_rs_hit(fwd_rs_hit),
    .fwd_rt_hit(fwd_rt_hit), .fwd_rs_data(fwd_rs_data),
    .fwd_rt_data(fwd_rt_data)
`endif
  );

  typedef logic [77:0] obs_t;

  typedef struct packed {
    logic          iv;
    logic [9:0]    ic;
    logic [31:0]   alu;
    logic [31:0]   wd;
    logic [4:0]    rd;
    logic [8:0]    oc;
    logic [31:0]   oalu;
    logic [31:0]   owd;
    logic [4:0]    ord;
    logic          llb;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  obs_t sbq[$];
  vec_t tbl[15];

  function automatic obs_t observe();
    return {out_valid, ExcTr, m_MemRead, m_MemWrite, m_MemHalf, m_MemByte,
            m_MemSignExtend, m_RegWrite, m_MemtoReg, m_ALUResult,
            m_WriteData, m_RegDst};
  endfunction

  function automatic obs_t exp_of(input vec_t v);
    return {v.oc, v.oalu, v.owd, v.ord};
  endfunction

  function automatic vec_t mk(input logic iv, input logic [9:0] ic,
                              input logic [31:0] alu, input logic [31:0] wd,
                              input logic [4:0] rd, input logic [8:0] oc,
                              input logic [31:0] oalu, input logic [31:0] owd,
                              input logic [4:0] ord, input logic llb);
    vec_t v;
    v.iv = iv; v.ic = ic; v.alu = alu; v.wd = wd; v.rd = rd;
    v.oc = oc; v.oalu = oalu; v.owd = owd; v.ord = ord; v.llb = llb;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    in_valid = v.iv;
    {Trap, TrapCond, LLSC, MemRead, MemWrite, MemHalf, MemByte,
     MemSignExtend, RegWrite, MemtoReg} = v.ic;
    ALUResult = v.alu;
    ReadData2 = v.wd;
    RegDstOut = v.rd;
  endtask

  task automatic idle();
    apply(mk(1'b0, 10'h0, 32'h0, 32'h0, 5'd0, 9'h0, 32'h0, 32'h0, 5'd0, 1'b0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t expA;
    // Table: latency/bubbles, load/store, trap hit/miss, LL/SC, bubble no-ops.
    tbl[0]  = mk(1'b1, 10'h002, 32'h1234, 32'h0, 5'd5, 9'h102, 32'h1234, 32'h0, 5'd5, 1'b0);
    tbl[1]  = mk(1'b0, 10'h002, 32'hDEAD, 32'h1, 5'd9, 9'h000, 32'h0, 32'h0, 5'd0, 1'b0);
    tbl[2]  = mk(1'b0, 10'h002, 32'hDEAD, 32'h1, 5'd9, 9'h000, 32'h0, 32'h0, 5'd0, 1'b0);
    tbl[3]  = mk(1'b1, 10'h057, 32'h100, 32'h55, 5'd3, 9'h157, 32'h100, 32'h55, 5'd3, 1'b0);
    tbl[4]  = mk(1'b1, 10'h028, 32'h200, 32'hCAFEBABE, 5'd0, 9'h128, 32'h200, 32'hCAFEBABE, 5'd0, 1'b0);
    tbl[5]  = mk(1'b1, 10'h320, 32'h1, 32'h77, 5'd4, 9'h180, 32'h1, 32'h77, 5'd4, 1'b0);
    tbl[6]  = mk(1'b1, 10'h320, 32'h0, 32'h77, 5'd4, 9'h120, 32'h0, 32'h77, 5'd4, 1'b0);
    tbl[7]  = mk(1'b1, 10'h242, 32'h2, 32'h0, 5'd6, 9'h180, 32'h2, 32'h0, 5'd6, 1'b0);
    tbl[8]  = mk(1'b1, 10'h0C3, 32'h300, 32'h0, 5'd8, 9'h143, 32'h300, 32'h0, 5'd8, 1'b1);
    tbl[9]  = mk(1'b1, 10'h0A2, 32'h300, 32'h99, 5'd8, 9'h122, 32'h1, 32'h99, 5'd8, 1'b0);
    tbl[10] = mk(1'b1, 10'h0A2, 32'h300, 32'h99, 5'd8, 9'h102, 32'h0, 32'h99, 5'd8, 1'b0);
    tbl[11] = mk(1'b0, 10'h0C3, 32'h300, 32'h0, 5'd8, 9'h000, 32'h0, 32'h0, 5'd0, 1'b0);
    tbl[12] = mk(1'b0, 10'h320, 32'h1, 32'h0, 5'd4, 9'h000, 32'h0, 32'h0, 5'd0, 1'b0);
    tbl[13] = mk(1'b0, 10'h000, 32'h0, 32'h0, 5'd0, 9'h000, 32'h0, 32'h0, 5'd0, 1'b0);
    tbl[14] = mk(1'b0, 10'h000, 32'h0, 32'h0, 5'd0, 9'h000, 32'h0, 32'h0, 5'd0, 1'b0);

    rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    idle();
`ifdef EXMEM_FWD_EN
    fwd_rs = '0; fwd_rt = '0;
`endif
    step(); step();
    check("reset_out", 128'(observe()), 128'(0));
    check("reset_llbit", 128'(LLBit), 128'(1'b0));
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i]);
      step();
      check($sformatf("llbit_%0d", i), 128'(LLBit), 128'(tbl[i].llb));
      if (i == 1) check("latency_early", 128'(out_valid), 128'(1'b0));
      sbq.push_back(exp_of(tbl[i]));
      if (sbq.size() == ST)
        check($sformatf("vec_%0d", i - ST + 1), 128'(observe()), 128'(sbq.pop_front()));
    end

    // Fill, stall four cycles with an SC waiting, then flush+stall together.
    apply(mk(1'b1, 10'h002, 32'h11, 32'h0, 5'd1, 9'h0, 32'h0, 32'h0, 5'd0, 1'b0)); step();
    apply(mk(1'b1, 10'h002, 32'h22, 32'h0, 5'd2, 9'h0, 32'h0, 32'h0, 5'd0, 1'b0)); step();
    apply(mk(1'b1, 10'h0C3, 32'h33, 32'h0, 5'd3, 9'h0, 32'h0, 32'h0, 5'd0, 1'b0)); step();
    expA = {9'h102, 32'h11, 32'h0, 5'd1};
    check("fill_out", 128'(observe()), 128'(expA));
    check("fill_llbit", 128'(LLBit), 128'(1'b1));
    Stall = 1'b1;
    apply(mk(1'b1, 10'h0A2, 32'h44, 32'h0, 5'd4, 9'h0, 32'h0, 32'h0, 5'd0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("stall_out_%0d", k), 128'(observe()), 128'(expA));
      check($sformatf("stall_llbit_%0d", k), 128'(LLBit), 128'(1'b1));
    end
    Flush = 1'b1;
    step();
    check("flush_stall_out", 128'(observe()), 128'(0));
    check("flush_stall_llbit", 128'(LLBit), 128'(1'b0));
    Flush = 1'b0; Stall = 1'b0;
    idle();
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("post_flush_valid_%0d", k), 128'(out_valid), 128'(1'b0));
    end

    // Trap held under stall keeps ExcTr high until advance.
    apply(mk(1'b1, 10'h320, 32'h1, 32'h5, 5'd2, 9'h0, 32'h0, 32'h0, 5'd0, 1'b0));
    step(); idle(); step(); step();
    check("trap_exc", 128'(ExcTr), 128'(1'b1));
    check("trap_memwrite", 128'(m_MemWrite), 128'(1'b0));
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("trap_stall_exc_%0d", k), 128'(ExcTr), 128'(1'b1));
    end
    Stall = 1'b0;
    step();
    check("trap_release_exc", 128'(ExcTr), 128'(1'b0));

    // LL, Flush, then SC: the SC must fail.
    apply(mk(1'b1, 10'h0C3, 32'h40, 32'h0, 5'd9, 9'h0, 32'h0, 32'h0, 5'd0, 1'b0));
    step();
    check("llsc_fail_ll", 128'(LLBit), 128'(1'b1));
    idle(); Flush = 1'b1;
    step();
    check("llsc_fail_flush", 128'(LLBit), 128'(1'b0));
    Flush = 1'b0;
    apply(mk(1'b1, 10'h0A2, 32'h40, 32'h66, 5'd9, 9'h0, 32'h0, 32'h0, 5'd0, 1'b0));
    step(); idle(); step(); step();
    check("llsc_fail_out", 128'(observe()), 128'({9'h102, 32'h0, 32'h66, 5'd9}));

    // Reset in the middle of a full chain drops everything.
    apply(mk(1'b1, 10'h002, 32'h81, 32'h0, 5'd1, 9'h0, 32'h0, 32'h0, 5'd0, 1'b0));
    step(); step(); step();
    check("midrst_before", 128'(out_valid), 128'(1'b1));
    rst = 1'b1;
    step();
    check("midrst_out", 128'(observe()), 128'(0));
    rst = 1'b0;
    idle();
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("midrst_drop_%0d", k), 128'(out_valid), 128'(1'b0));
    end

`ifdef EXMEM_FWD_EN
    // Two in-flight writers of r7: the younger one (0xAA) must win.
    apply(mk(1'b1, 10'h002, 32'hBB, 32'h0, 5'd7, 9'h0, 32'h0, 32'h0, 5'd0, 1'b0)); step();
    apply(mk(1'b1, 10'h002, 32'hAA, 32'h0, 5'd7, 9'h0, 32'h0, 32'h0, 5'd0, 1'b0)); step();
    idle(); Stall = 1'b1;
    fwd_rs = 5'd7; fwd_rt = 5'd0;
    #1;
    check("fwd_rs_hit", 128'(fwd_rs_hit), 128'(1'b1));
    check("fwd_rs_data", 128'(fwd_rs_data), 128'(32'hAA));
    check("fwd_rt_zero_hit", 128'(fwd_rt_hit), 128'(1'b0));
    fwd_rs = 5'd0;
    #1;
    check("fwd_rs_zero_hit", 128'(fwd_rs_hit), 128'(1'b0));
    Stall = 1'b0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX->MEM pipeline register chain. It replaces the single fixed EX/MEM latch with a depth-configurable, valid-tagged chain.
- Adds trap resolution, LL/SC link-bit tracking, and flush/stall priority handling.
- Sits between the execute stage (ALU) and the memory stage. It feeds the MEM stage and the hazard unit.

Parameters:
- DATA_W, 32, ALU result and store-data width
- REG_W, 5, register-index width
- STAGES, 1, number of register slices in the chain (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Stall  in  1  freeze entire chain
- Flush  in  1  from CP0; kill all in-flight entries
- in_valid  in  1  EX holds a real instruction
- Trap, TrapCond, LLSC, MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, RegWrite, MemtoReg  in  1 each  EX control
- ALUResult  in  DATA_W  EX result
- ReadData2  in  DATA_W  store data
- RegDstOut  in  REG_W  destination register
- out_valid  out  1  final slice holds a live instruction
- m_MemRead, m_MemWrite, m_MemHalf, m_MemByte, m_MemSignExtend, m_RegWrite, m_MemtoReg  out  1 each  qualified controls to MEM
- m_ALUResult  out  DATA_W  result, or SC status
- m_WriteData  out  DATA_W  store data
- m_RegDst  out  REG_W  destination register
- ExcTr  out  1  trap exception, pulse from final slice
- LLBit  out  1  current link bit

Behaviour:
- Reset (rst=1 at posedge):
  - all slice valids=0, LLBit=0
  - all outputs 0, including ExcTr
- Interface decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Latency:
  - an entry accepted at edge N appears at outputs after edge N+STAGES-1, i.e. STAGES cycles after being presented at the inputs
  - outputs are registered only, with no combinational in->out path
- Priority per edge: rst > Flush > Stall > advance.
- Flush:
  - all slice valids cleared and LLBit cleared, even when Stall=1
  - the entry presented at the inputs in the same cycle is discarded
- Stall (no Flush): every slice, LLBit and the outputs hold their values.
- Advance: slice0 <= inputs with valid=in_valid; slice k <= slice k-1.
- Bubbles (valid=0) propagate. Every m_* control is ANDed with the slice valid, so a bubble drives zeros.
- Trap, evaluated at slice0 capture:
  - trap_hit = in_valid & Trap & (ALUResult[0] == TrapCond)
  - the trap_hit flag travels with the entry
  - in the final slice: ExcTr=1 for that one cycle, and RegWrite, MemRead and MemWrite are forced to 0
  - a trap does not self-flush; CP0 asserts Flush
- LL/SC, evaluated at slice0 capture, in-order:
  - LL (LLSC & MemRead & in_valid): LLBit <= 1
  - SC (LLSC & MemWrite & in_valid):
    - the entry carries sc_ok = LLBit as held at capture, and LLBit <= 0
    - sc_ok=0: MemWrite is suppressed and the result becomes 0
    - sc_ok=1: the result becomes 1
    - in both cases RegWrite remains set
  - LL and SC in consecutive cycles: the SC sees LLBit=1. This is a register-to-register path, so there is no hazard.
- Boundaries:
  - STAGES=1 is a plain latch with the added features
  - Stall held indefinitely keeps out_valid and ExcTr constant. A trap under stall therefore keeps ExcTr high until advance or Flush.
  - Flush and Stall asserted together: Flush wins
  - rst asserted mid-operation drops all entries
- Width: results are passed through with no arithmetic. SC status is zero-extended to DATA_W.

Optional Feature:
- EXMEM_FWD_EN.
- When defined, adds these ports:
  - fwd_rs, fwd_rt  in  REG_W each
  - fwd_rs_hit, fwd_rt_hit  out  1 each
  - fwd_rs_data, fwd_rt_data  out  DATA_W each
- Combinational behaviour:
  - scan the slices youngest to oldest; the youngest valid slice with RegWrite=1, not trapped, and RegDst == source register (source register != 0) wins
  - hit=1 and data = that slice's result
  - a MemtoReg match gives hit=1 and data=0; the hazard unit stalls on it
- Undefined: the ports are absent and there is no scan logic.

Decomposition:
- exmem_pkg:
  - exmem_ctrl_t struct holding the 10 control bits plus trap_hit and sc_ok
  - exmem_slice_t struct holding valid, ctrl, result, wdata and regdst
  - MAX_STAGES=4 constant
- One sub-module, exmem_slice: a single register slice with stall/flush inputs, generated STAGES times.
- Trap, LL/SC and forwarding logic live in ex_mem_pipe.

Test Plan:
- Latency and bubbles: STAGES=3; valid entry with ALUResult=0x1234, RegDst=5, RegWrite=1, followed by 2 bubbles -> out_valid=1 with m_ALUResult=0x1234 exactly 3 cycles later; the bubbles give m_RegWrite=0.
- Stall and flush together: with the chain full, assert Stall for 4 cycles -> outputs held. Then assert Flush and Stall together -> out_valid=0 and LLBit=0 on the next cycle.
- Trap: Trap=1, TrapCond=1, ALUResult=0x1, MemWrite=1 -> final slice gives ExcTr=1 for one cycle and m_MemWrite=0. With ALUResult=0x0 -> ExcTr=0.
- LL/SC success: LL then SC on consecutive cycles -> SC output m_ALUResult=1, m_MemWrite=1, LLBit=0 afterwards.
- LL/SC failure: LL, Flush, then SC -> m_ALUResult=0, m_MemWrite=0, m_RegWrite=1.
- Forwarding (EXMEM_FWD_EN, STAGES=2): slice0 holds RegDst=7 with 0xAA and slice1 holds RegDst=7 with 0xBB; fwd_rs=7 -> hit=1, data=0xAA. fwd_rs=0 -> hit=0.
